// File: rtl/uart_rx_module_pkg.sv
// uart_rx_module_pkg
// Shared UART definitions for the receive path (and reusable by the transmit
// path): oversample rate, default tick divider, frame width and the receiver
// state encoding.
// No ports; import with `import uart_rx_module_pkg::*;`.
package uart_rx_module_pkg;

  // 16 oversample ticks per bit; the middle of a bit is 8 ticks in.
  localparam int OVS_RATE        = 16;
  localparam int OVS_MID         = OVS_RATE / 2;

  // 50 MHz clock / (115200 baud * 16) ~= 27 clk per oversample tick.
  localparam int DEFAULT_OVS_DIV = 27;

  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_module_baud_tick.sv
// uart_baud_tick
// Oversample tick generator. It counts 0..OVS_DIV-1 and raises tick for one
// clk while the count sits at OVS_DIV-1. clr restarts the count at 0 so that
// the receiver can align tick phase to a detected start edge.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous counter clear
//   tick - one-clk pulse every OVS_DIV clk
module uart_baud_tick
  import uart_rx_module_pkg::*;
#(
  parameter int OVS_DIV = DEFAULT_OVS_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Not gated by clr: the receiver asserts clr in the same cycle it consumes
  // a tick, and gating here would form a combinational loop.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_module.sv
// uart_rx_module
// 8N1 UART receiver with 16x oversampling. The line is synchronised, a
// falling edge starts a frame, the start bit is re-checked at mid-bit (glitch
// rejection), then each data bit and the stop bit are sampled mid-bit.
// Ports:
//   clk       - system clock, all state on rising edge
//   rst       - asynchronous active-high reset
//   rx        - serial line, idle high, asynchronous to clk
//   data_out  - last correctly framed byte (LSB received first)
//   valid     - one-clk pulse, data_out updated in this cycle
//   frame_err - one-clk pulse, stop bit sampled low
//   busy      - high in every state except IDLE
//   state_dbg - current receiver state encoding
module uart_rx_module
  import uart_rx_module_pkg::*;
#(
  parameter int OVS_DIV   = DEFAULT_OVS_DIV,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] MID_TICK  = 4'(OVS_MID - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVS_RATE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  uart_rx_state_e state, state_next;

  logic       rx_m, rx_s;
  logic       tick, clr;
  logic [3:0] ovs_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;

  logic ovs_clr, sample_bit, load_data, set_ferr;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_baud_tick #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    ovs_clr    = 1'b0;
    sample_bit = 1'b0;
    load_data  = 1'b0;
    set_ferr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          clr        = 1'b1;
          ovs_clr    = 1'b1;
        end
      end
      ST_START: begin
        // Mid start bit: re-aligning the counters here makes every later
        // 16th tick land mid-bit.
        if (tick && (ovs_cnt == MID_TICK)) begin
          clr        = 1'b1;
          ovs_clr    = 1'b1;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && (ovs_cnt == LAST_TICK)) begin
          sample_bit = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick && (ovs_cnt == LAST_TICK)) begin
          if (rx_s) begin
            load_data  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A line held low (break) must not be taken as a new start bit.
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers. ovs_cnt wraps 15->0 and bit_cnt 7->0 on their own,
  // so no explicit clear is needed between bits or at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovs_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovs_clr) begin
        ovs_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        if (tick && (state != ST_IDLE)) begin
          ovs_cnt <= ovs_cnt + 1'b1;
        end
        if (sample_bit) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (sample_bit) begin
        // LSB arrives first, so new bits enter at the MSB and shift right.
        shift_reg <= {rx_s, shift_reg[7:1]};
      end
      if (load_data) begin
        data_out <= shift_reg;
      end
      valid     <= load_data;
      frame_err <= set_ferr;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module
// Directed bench for uart_rx_module at OVS_DIV=4 (64 clk per bit). A table
// of frames is replayed with expected pulse counts and data, followed by
// hand-written sequences for back-to-back frames, start glitch, break after
// a bad stop bit and reset during a frame.
module tb_uart_rx_module;
  import uart_rx_module_pkg::*;

  localparam int OVS_DIV   = 4;
  localparam int BIT_CLK   = 16 * OVS_DIV;
  localparam int FRAME_CLK = 10 * BIT_CLK;
  localparam int LATENCY   = (8 + 16 * 9) * OVS_DIV + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         vcyc_q[$];
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         last_pulse_cyc = 0;
  int         start_cyc = 0;
  bit         overlap_seen = 0;
  bit         hold_broken  = 0;
  bit         double_valid = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_byte;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         jit;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  uart_rx_module #(.OVS_DIV(OVS_DIV), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_data  = data_out;
      prev_valid = 1'b0;
    end else begin
      if (valid && frame_err) overlap_seen = 1;
      if (valid && prev_valid) double_valid = 1;
      if (!valid && (data_out !== prev_data)) hold_broken = 1;
      if (valid) begin
        valid_cnt++;
        vcyc_q.push_back(cyc);
        last_pulse_cyc = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got data_out=%h, required no valid pulse", data_out);
        end else begin
          exp_byte = exp_q.pop_front();
          if (data_out !== exp_byte) begin
            n_fail++;
            $display("FAIL valid_data: got %h, required %h", data_out, exp_byte);
          end
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        last_pulse_cyc = cyc;
      end
      prev_valid = valid;
      prev_data  = data_out;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_tests++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting now (caller is at a negedge). Odd-numbered bit
  // edges move by +jit clk, even-numbered by -jit clk. The stop bit level is
  // left on the line when the task returns.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int jit);
    int t_prev;
    int t_k;
    rx        = 1'b0;
    start_cyc = cyc;
    t_prev    = 0;
    for (int k = 1; k <= 9; k++) begin
      t_k = k * BIT_CLK + (((k % 2) == 1) ? jit : -jit);
      wait_clk(t_k - t_prev);
      rx     = (k <= 8) ? d[k-1] : stop_bit;
      t_prev = t_k;
    end
    wait_clk(FRAME_CLK - t_prev);
  endtask

  // ---------------- test ----------------
  initial begin
    int v0, f0, busy_cyc;

    vecs[0] = '{8'hA5, 1'b1,  0, 1, 0, 8'hA5};
    vecs[1] = '{8'h55, 1'b1,  6, 1, 0, 8'h55};
    vecs[2] = '{8'h55, 1'b1, -6, 1, 0, 8'h55};
    vecs[3] = '{8'h3C, 1'b0,  0, 0, 1, 8'h55};
    vecs[4] = '{8'h81, 1'b1,  3, 1, 0, 8'h81};
    vecs[5] = '{8'hC3, 1'b1, -4, 1, 0, 8'hC3};

    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(4);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    wait_clk(10);

    // Table-driven frames, each followed by 40 idle-high clk.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      if (vecs[i].exp_valid == 1) exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].jit);
      rx = 1'b1;
      wait_clk(40);
      check($sformatf("vec%0d_valid_count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ferr_count", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy_after", i), 32'(busy), 0);
      check_range($sformatf("vec%0d_pulse_latency", i), last_pulse_cyc - start_cyc,
                  LATENCY - 1, LATENCY + 1);
    end

    // Back-to-back 0x00 then 0xFF with no idle gap.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    vcyc_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    wait_clk(40);
    check("b2b_valid_count", 32'(valid_cnt - v0), 2);
    check("b2b_ferr_count", 32'(ferr_cnt - f0), 0);
    check("b2b_data_out", 32'(data_out), 32'hFF);
    if (vcyc_q.size() == 2) begin
      check("b2b_spacing", 32'(vcyc_q[1] - vcyc_q[0]), 32'(FRAME_CLK));
    end else begin
      check("b2b_pulse_records", 32'(vcyc_q.size()), 2);
    end

    // 20 clk low glitch must be rejected at the mid start-bit check.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      rx = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    check_range("glitch_busy_cycles", busy_cyc, 1, 35);
    check("glitch_valid_count", 32'(valid_cnt - v0), 0);
    check("glitch_ferr_count", 32'(ferr_cnt - f0), 0);
    check("glitch_state", 32'(state_dbg), 32'(ST_IDLE));

    // 0x3C with a low stop bit, then line held low (break) for 300 clk.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0);
    wait_clk(300);
    check("break_ferr_count", 32'(ferr_cnt - f0), 1);
    check("break_valid_count", 32'(valid_cnt - v0), 0);
    check("break_data_kept", 32'(data_out), 32'hFF);
    check("break_busy_low_line", 32'(busy), 1);
    check("break_state", 32'(state_dbg), 32'(ST_WAIT_HIGH));
    rx = 1'b1;
    wait_clk(10);
    check("break_busy_released", 32'(busy), 0);
    check("break_ferr_total", 32'(ferr_cnt - f0), 1);

    // Reset during bit 4 of 0x5A, then a clean 0x81.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int b = 0; b < 5; b++) begin
      rx = b[0] ? 1'b1 : 1'b0;  // bits of 0x5A LSB first: 0,1,0,1,1
      if (b == 4) rx = 1'b1;
      wait_clk((b == 4) ? 30 : BIT_CLK);
    end
    check("abort_busy_before_rst", 32'(busy), 1);
    rx = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("abort_busy_async", 32'(busy), 0);
    check("abort_data_out_async", 32'(data_out), 32'h00);
    check("abort_state_async", 32'(state_dbg), 32'(ST_IDLE));
    wait_clk(5);
    rst = 1'b0;
    wait_clk(20);
    check("abort_no_valid", 32'(valid_cnt - v0), 0);
    check("abort_no_ferr", 32'(ferr_cnt - f0), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0);
    rx = 1'b1;
    wait_clk(40);
    check("post_rst_valid_count", 32'(valid_cnt - v0), 1);
    check("post_rst_data_out", 32'(data_out), 32'h81);
    check_range("post_rst_latency", last_pulse_cyc - start_cyc, LATENCY - 1, LATENCY + 1);

    // Whole-run properties.
    check("exp_queue_drained", 32'(exp_q.size()), 0);
    check("valid_ferr_overlap", 32'(overlap_seen), 0);
    check("valid_two_cycles", 32'(double_valid), 0);
    check("data_out_hold", 32'(hold_broken), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
